// File: rtl/alm_prod_acc_pkg.sv
// Shared types and constants for the approximate-log-multiplier product accumulator.
package alm_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned ACC_W_DEF   = 24;
  localparam int unsigned MAX_LEN_DEF = 256;

  // Returned 64 bits wide; callers truncate to their own accumulator width.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/alm_prod_acc_if.sv
// Product-in / result-out handshake bundle for alm_prod_acc.
interface alm_prod_acc_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 9
);
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic signed [15:0]      in_data_i;
  logic                    in_last_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic signed [ACC_W-1:0] out_data_o;
  logic [CNT_W-1:0]        out_cnt_o;
  logic                    ovf_o;

  modport slave (
    input  in_valid_i, in_data_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_cnt_o, ovf_o
  );

  modport master (
    output in_valid_i, in_data_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_cnt_o, ovf_o
  );
endinterface

// File: rtl/alm_prod_acc_sat_add.sv
// Combinational signed adder with overflow flag; clamps on overflow when
// ALM_PROD_ACC_SAT_EN is defined, otherwise wraps.
module alm_sat_add
  import alm_acc_pkg::*;
#(
  parameter int unsigned W = 24
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o,
  output logic                ovf_o
);
  logic signed [W-1:0] raw;

  assign raw   = a_i + b_i;
  assign ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);

`ifdef ALM_PROD_ACC_SAT_EN
  always_comb begin
    sum_o = raw;
    if (ovf_o) begin
      sum_o = a_i[W-1] ? W'(sat_min(W)) : W'(sat_max(W));
    end
  end
`else
  assign sum_o = raw;
`endif

endmodule

// File: rtl/alm_prod_acc.sv
// Streaming dot-product accumulator for signed 16-bit products.
// Optional saturation: define ALM_PROD_ACC_SAT_EN.
module alm_prod_acc
  import alm_acc_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  alm_prod_acc_if.slave  bus
);
  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;

  logic                    accept;
  logic [CNT_W-1:0]        cnt_inc;
  logic signed [ACC_W-1:0] add_a, add_b, add_sum;
  logic                    add_ovf;

  assign bus.in_ready_o  = (state_q != HOLD);
  assign bus.out_valid_o = (state_q == HOLD);
  assign bus.out_data_o  = acc_q;
  assign bus.out_cnt_o   = cnt_q;
  assign bus.ovf_o       = ovf_q;

  assign accept  = bus.in_valid_i && bus.in_ready_o;
  assign cnt_inc = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);

  // First product of a vector is added to zero, so it can never overflow.
  assign add_a = (state_q == IDLE) ? '0 : acc_q;
  assign add_b = ACC_W'(bus.in_data_i);

  alm_sat_add #(.W(ACC_W)) u_add (
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            acc_d   = add_sum;
            cnt_d   = cnt_inc;
            ovf_d   = ((state_q == ACC) && ovf_q) || add_ovf;
            state_d = (bus.in_last_i || cnt_inc == CNT_W'(MAX_LEN)) ? HOLD : ACC;
          end
        end
        HOLD: begin
          if (bus.out_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alm_prod_acc.sv
// Randomized + directed bench for alm_prod_acc (ACC_W=16, MAX_LEN=4) against a
// vector-level reference model.
module tb_alm_prod_acc;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
  localparam longint      SMAX    = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint      SMIN    = -(64'sd1 <<< (ACC_W - 1));

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  int errors = 0;
  int checks = 0;

  alm_prod_acc_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  alm_prod_acc #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: products of the open vector, plus the pending finished result.
  int     vec[$];
  bit     pending;
  longint res_sum;
  int     res_cnt;
  bit     res_ovf;

  function automatic void fold(output longint s, output bit o);
    longint t;
    s = 0;
    o = 1'b0;
    foreach (vec[i]) begin
      t = s + vec[i];
      if (t > SMAX || t < SMIN) begin
        o = 1'b1;
`ifdef ALM_PROD_ACC_SAT_EN
        t = (t > SMAX) ? SMAX : SMIN;
`else
        t = (t > SMAX) ? t - (64'sd1 <<< ACC_W) : t + (64'sd1 <<< ACC_W);
`endif
      end
      s = t;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec.delete();
      pending = 1'b0;
    end else if (clr) begin
      vec.delete();
      pending = 1'b0;
    end else if (pending) begin
      if (bus.out_ready_i) pending = 1'b0;
    end else if (bus.in_valid_i) begin
      vec.push_back(int'(bus.in_data_i));
      if (bus.in_last_i || vec.size() == MAX_LEN) begin
        fold(res_sum, res_ovf);
        res_cnt = vec.size();
        pending = 1'b1;
        vec.delete();
      end
    end
  end

  always @(negedge clk) begin
    chk("no_x", longint'($isunknown({bus.in_ready_o, bus.out_valid_o, bus.out_data_o,
                                     bus.out_cnt_o, bus.ovf_o})), 0);
    chk("in_ready", longint'(bus.in_ready_o), longint'(!pending));
    chk("out_valid", longint'(bus.out_valid_o), longint'(pending));
    if (pending) begin
      chk("out_data", longint'(bus.out_data_o), res_sum);
      chk("out_cnt", longint'(bus.out_cnt_o), longint'(res_cnt));
      chk("ovf", longint'(bus.ovf_o), longint'(res_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the beat until it is accepted; bounded so a stuck ready cannot hang.
  task automatic send(input int data, input bit last);
    bit r;
    int n = 0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 16'(data);
    bus.in_last_i  = last;
    do begin
      r = bus.in_ready_o;
      tick();
      n++;
    end while (!r && n < 50);
    if (!r) chk("send_timeout", 1, 0);
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
  endtask

  task automatic expect_result(input string name, input longint d, input longint c, input longint o);
    chk({name, "_valid"}, longint'(bus.out_valid_o), 1);
    chk({name, "_data"}, longint'(bus.out_data_o), d);
    chk({name, "_cnt"}, longint'(bus.out_cnt_o), c);
    chk({name, "_ovf"}, longint'(bus.ovf_o), o);
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_data_i = '0;
    bus.in_last_i = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (2) tick();
    chk("rst_valid", longint'(bus.out_valid_o), 0);
    chk("rst_data", longint'(bus.out_data_o), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", longint'(bus.in_ready_o), 1);

    // Reset mid-vector
    send(100, 0);
    send(200, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_data", longint'(bus.out_data_o), 0);
    chk("midrst_cnt", longint'(bus.out_cnt_o), 0);
    chk("midrst_valid", longint'(bus.out_valid_o), 0);
    tick();
    rst_n = 1'b1;
    chk("midrst_ready", longint'(bus.in_ready_o), 1);
    send(9, 1);
    expect_result("fresh", 9, 1, 0);
    tick();

    // Basic vector, consumer always ready
    send(100, 0);
    send(-50, 0);
    send(16129, 1);
    expect_result("basic", 16179, 3, 0);
    chk("basic_ready_low", longint'(bus.in_ready_o), 0);
    tick();
    chk("basic_ready_back", longint'(bus.in_ready_o), 1);
    chk("basic_valid_drop", longint'(bus.out_valid_o), 0);

    // Backpressure
    bus.out_ready_i = 1'b0;
    send(100, 0);
    send(-50, 0);
    send(16129, 1);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 16'sd5;
    bus.in_last_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_result("bp_hold", 16179, 3, 0);
      chk("bp_ready", longint'(bus.in_ready_o), 0);
    end
    bus.out_ready_i = 1'b1;
    tick();
    chk("bp_release_ready", longint'(bus.in_ready_o), 1);
    tick();
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
    expect_result("bp_next", 5, 1, 0);
    tick();

    // Forced termination at MAX_LEN
    for (int i = 0; i < 4; i++) send(1, 0);
    expect_result("force", 4, 4, 0);
    send(1, 0);
    send(0, 1);
    expect_result("force_next", 1, 2, 0);
    tick();

    // Overflow
    send(16000, 0);
    send(16000, 0);
    send(16000, 1);
`ifdef ALM_PROD_ACC_SAT_EN
    expect_result("ovf", 32767, 3, 1);
`else
    expect_result("ovf", -17536, 3, 1);
`endif
    tick();
    send(1, 1);
    expect_result("ovf_clear", 1, 1, 0);
    tick();

    // clr_i in HOLD and in ACC, concurrent beats dropped
    bus.out_ready_i = 1'b0;
    send(9, 1);
    clr = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 16'sd123;
    bus.in_last_i  = 1'b1;
    tick();
    clr = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
    chk("clr_valid", longint'(bus.out_valid_o), 0);
    chk("clr_ready", longint'(bus.in_ready_o), 1);
    send(50, 0);
    clr = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 16'sd60;
    tick();
    clr = 1'b0;
    bus.in_valid_i = 1'b0;
    send(7, 1);
    expect_result("clr_next", 7, 1, 0);
    bus.out_ready_i = 1'b1;
    tick();

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid_i  = ($urandom_range(9) < 7);
      bus.in_data_i   = ($urandom_range(3) == 0) ? 16'($urandom_range(32767) | 16'h4000)
                                                 : 16'($urandom);
      bus.in_last_i   = ($urandom_range(3) == 0);
      bus.out_ready_i = ($urandom_range(9) < 6);
      clr             = ($urandom_range(49) == 0);
      tick();
    end
    bus.in_valid_i = 1'b0;
    clr = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alm_prod_acc.md
Name: alm_prod_acc

Overview:
- Streaming accumulator directly downstream of the 8-bit approximate log multiplier.
- Consumes its 16-bit signed products over a valid/ready handshake and sums one vector of products (dot-product style).
- Presents the sign-extended sum, element count and overflow flag on an output valid/ready port.
- Accepts one product per cycle; stalls only while a finished result is unread.

Parameters:
- ACC_W, 24, accumulator and result width in bits (signed, >= 17).
- MAX_LEN, 256, maximum number of products per vector; the vector is force-terminated at this count.
- CNT_W, $clog2(MAX_LEN+1), width of the element counter and of cnt_o.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- clr_i  input  1  synchronous flush; abandons the current vector.
- in_valid_i  input  1  product valid.
- in_ready_o  output  1  block can accept a product.
- in_data_i  input  16  signed product from the multiplier.
- in_last_i  input  1  marks the final product of a vector.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- out_data_o  output  ACC_W  signed accumulated sum.
- out_cnt_o  output  CNT_W  number of products summed.
- ovf_o  output  1  signed overflow occurred in this vector.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, accumulator=0, count=0, out_valid_o=0, out_data_o=0, out_cnt_o=0, ovf_o=0.
- After reset, in_ready_o=1.
- Input accept = in_valid_i & in_ready_o.
- Output handshake = out_valid_o & out_ready_i.
- in_ready_o = (state != HOLD), combinational from state only.
- The block never depends on in_valid_i to drive ready.
- FSM states:
  - IDLE: on accept, acc = sext(in_data_i), cnt = 1, ovf = 0. Next state is HOLD if in_last_i or MAX_LEN==1, else ACC.
  - ACC: on accept, acc = acc + sext(in_data_i), cnt = cnt + 1. Next state is HOLD if in_last_i or the new cnt == MAX_LEN, else stay in ACC. With no accept, hold all state.
  - HOLD: out_valid_o=1; out_data_o, out_cnt_o and ovf_o are stable until handshake. On handshake, next state is IDLE and out_valid_o=0 the next cycle.
- Latency: final product accepted at edge t, so out_valid_o=1 from cycle t+1.
- Throughput: a new vector's first product is accepted in the cycle after the output handshake.
- Arithmetic: two's complement, product sign-extended to ACC_W.
- Overflow is detected when the operand signs are equal and the result sign differs.
- ovf is sticky within a vector and cleared on the first accept of the next vector.
- clr_i=1 (synchronous, highest priority after reset): next state is IDLE, acc=0, cnt=0, out_valid_o=0, ovf=0. Any concurrent input beat is dropped, and a pending HOLD result is discarded.
- Forced termination: reaching cnt==MAX_LEN without in_last_i still goes to HOLD. A later in_last_i is treated as an ordinary product of a new vector.
- out_data_o, out_cnt_o and ovf_o are registered. Their values outside HOLD are don't-care for checking but must not be X.

Optional Feature:
- Macro: ALM_PROD_ACC_SAT_EN.
- Defined: on overflow the accumulator clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1), following the operand sign. It stays clamped until the next add moves it back in range, and ovf_o is asserted.
- Undefined: the sum wraps modulo 2^ACC_W and ovf_o is still reported.

Decomposition:
- Package alm_acc_pkg: state enum (IDLE, ACC, HOLD), default ACC_W/MAX_LEN constants, and functions returning the saturation max/min for a given width.
- One sub-module, alm_sat_add: a combinational ACC_W signed adder with an overflow output.
  - Its saturation mux is compiled under ALM_PROD_ACC_SAT_EN.
  - It is instantiated once by alm_prod_acc, which owns the FSM, counter and handshakes.

Test Plan:
- Reset mid-vector: apply products 100 and 200, then pulse rst_n low asynchronously -> all outputs 0 immediately, in_ready_o=1 after release, and the next vector starts fresh.
- Basic vector, out_ready_i=1: products 100, -50, 16129 (last) -> out_valid_o one cycle after last accept, out_data_o=16179, out_cnt_o=3, ovf_o=0, in_ready_o=0 for exactly one cycle.
- Backpressure: same vector with out_ready_i=0 for 5 cycles -> result stable, in_ready_o=0 and input held off. After out_ready_i=1, the next vector's first beat is accepted the following cycle.
- Forced termination with MAX_LEN=4: feed 5 products of 1, no last -> first result out_data_o=4, cnt=4. The 5th product starts a new vector with cnt=1.
- Overflow with ACC_W=16: products 16000, 16000, 16000 (last) -> SAT_EN gives 32767, ovf=1; without the macro gives 48000-65536=-17536, ovf=1.
- clr_i while in HOLD: result discarded, out_valid_o=0 next cycle. A product on the same cycle as clr_i is dropped, and a subsequent vector of 7 (last) returns 7, cnt=1.
